// File: rtl/mips_ctrl_pkg.sv
// Purpose : shared constants for the multicycle MIPS control FSM: state enum,
//           opcode/funct encodings, ALUControl encodings and datapath select codes.
// Latency : n/a (package). Backpressure: n/a.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOp classes handed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_ctrl_alu_decoder.sv
// Purpose : combinational map of {ALUOp, Funct} to ALUControl plus an unknown-funct flag.
// Latency : 0 cycles (pure combinational). Backpressure: none.
// Ports   : alu_op_i, funct_i in; alu_control_o, funct_illegal_o out.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       funct_illegal_o
);

  always_comb begin
    alu_control_o   = ALU_ADD;
    funct_illegal_o = 1'b0;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FUNCT_ADD: alu_control_o = ALU_ADD;
          FUNCT_SUB: alu_control_o = ALU_SUB;
          FUNCT_AND: alu_control_o = ALU_AND;
          FUNCT_OR:  alu_control_o = ALU_OR;
          FUNCT_SLT: alu_control_o = ALU_SLT;
          default:   funct_illegal_o = 1'b1; // ALUControl stays at add
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Purpose : Moore control FSM sequencing a multicycle MIPS datapath over one shared memory port.
// Latency : lw 5, sw/R/addi 4, beq/j 3 cycles with zero-wait memory; +1 per MemReady-low cycle.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold MemReq, address and MemWrite until MemReady=1.
// Ports   : CLK, Reset (sync active-high), Op, Funct, Zero, MemReady in;
//           MemReq, IorD, MemWrite, IRWrite, RegDST, MemtoReg, RegWrite, ALUSrcA,
//           ALUSrcB, ALUControl, PCSrc, PCEn, Illegal out.
// Option  : define CTRL_BNE_EN to decode bne (Op 000101) as a branch on ~Zero.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDST,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Illegal
);

  state_t     state_q, state_d;
  state_t     state_eff;
  logic [1:0] alu_op;
  logic       funct_illegal;
  logic       branch_take;

  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // While Reset is high the outputs show FETCH values, whatever the state register holds.
  assign state_eff = Reset ? S_FETCH : state_q;

  mips_alu_decoder u_alu_dec (
    .alu_op_i        (alu_op),
    .funct_i         (Funct),
    .alu_control_o   (ALUControl),
    .funct_illegal_o (funct_illegal)
  );

  always_comb begin
    state_d  = state_q;
    MemReq   = 1'b0;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDST   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_REG;
    PCSrc    = PCSRC_ALURES;
    PCEn     = 1'b0;
    Illegal  = 1'b0;
    alu_op   = ALUOP_ADD;

`ifdef CTRL_BNE_EN
    branch_take = (Op == OP_BNE) ? ~Zero : Zero;
`else
    branch_take = Zero;
`endif

    case (state_eff)
      S_FETCH: begin
        MemReq  = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCEn    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH; // precompute branch target into ALUOut
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef CTRL_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            Illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
        if (funct_illegal) begin
          Illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_ALUWB: begin
        RegDST   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        PCSrc   = PCSRC_ALUOUT;
        PCEn    = branch_take;
        state_d = S_FETCH;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCEn    = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset aborts any in-flight instruction: no strobes or write enables escape.
    if (Reset) begin
      MemReq   = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCEn     = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Purpose : self-checking bench for mips_multicycle_ctrl; per-cycle expected outputs are
//           built from the instruction-level rules, plus literal instruction-length checks.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] T_R = 6'b000000, T_J = 6'b000010, T_BEQ = 6'b000100;
  localparam logic [5:0] T_BNE = 6'b000101, T_ADDI = 6'b001000;
  localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_BAD = 6'b111111;

`ifdef CTRL_BNE_EN
  localparam bit BNE_OK = 1'b1;
  localparam int BNE_LEN = 3;
`else
  localparam bit BNE_OK = 1'b0;
  localparam int BNE_LEN = 2;
`endif

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       rdy;
    logic       zero;
    logic [7:0] id;
    out_t       exp;
  } rec_t;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] Op = '0;
  logic [5:0] Funct = '0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, IorD, MemWrite, IRWrite, RegDST, MemtoReg, RegWrite, ALUSrcA, PCEn, Illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  out_t       act;

  always #5 CLK = ~CLK;

  mips_multicycle_ctrl dut (
    .CLK(CLK), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDST(RegDST), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal)
  );

  assign act = {MemReq, IorD, MemWrite, IRWrite, RegDST, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUControl, PCSrc, PCEn, Illegal};

  rec_t q[$];
  int   irw[$];
  int   exp_int[$];
  int   errors = 0;
  int   checks = 0;
  int   cur_id = 0;

  function automatic out_t base();
    out_t o;
    o = '0;
    o.alu = 3'b010;
    return o;
  endfunction

  // {known, ALUControl} for an R-type funct
  function automatic logic [3:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b1_010;
      6'b100010: return 4'b1_110;
      6'b100100: return 4'b1_000;
      6'b100101: return 4'b1_001;
      6'b101010: return 4'b1_111;
      default:   return 4'b0_010;
    endcase
  endfunction

  task automatic push(input logic rst, input logic [5:0] op, input logic [5:0] funct,
                      input logic rdy, input logic zero, input out_t o);
    rec_t r;
    r.rst = rst; r.op = op; r.funct = funct; r.rdy = rdy; r.zero = zero;
    r.id = 8'(cur_id); r.exp = o;
    q.push_back(r);
  endtask

  task automatic reset_cycle();
    out_t o;
    o = base();
    o.src_b = 2'b01;
    push(1'b1, T_R, 6'b100000, 1'b1, 1'b1, o);
  endtask

  // Expected per-cycle trace of one instruction: fw fetch waits, mw memory waits,
  // ro = MemReady level driven in cycles where memory is not being accessed.
  task automatic instr(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                       input int fw, input int mw, input logic ro);
    out_t o;
    logic [3:0] fa;
    bit known;
    cur_id++;
    for (int i = 0; i < fw; i++) begin
      o = base(); o.mem_req = 1; o.src_b = 2'b01;
      push(0, op, funct, 0, zero, o);
    end
    o = base(); o.mem_req = 1; o.src_b = 2'b01; o.ir_write = 1; o.pc_en = 1;
    push(0, op, funct, 1, zero, o);
    known = (op == T_LW) || (op == T_SW) || (op == T_R) || (op == T_BEQ) ||
            (op == T_ADDI) || (op == T_J) || ((op == T_BNE) && BNE_OK);
    o = base(); o.src_b = 2'b11;
    if (!known) begin
      o.illegal = 1;
      push(0, op, funct, ro, zero, o);
      return;
    end
    push(0, op, funct, ro, zero, o);
    if (op == T_LW || op == T_SW) begin
      o = base(); o.src_a = 1; o.src_b = 2'b10;
      push(0, op, funct, ro, zero, o);
      o = base(); o.mem_req = 1; o.iord = 1; o.mem_write = (op == T_SW);
      for (int i = 0; i < mw; i++) push(0, op, funct, 0, zero, o);
      push(0, op, funct, 1, zero, o);
      if (op == T_LW) begin
        o = base(); o.mem_to_reg = 1; o.reg_write = 1;
        push(0, op, funct, ro, zero, o);
      end
    end else if (op == T_R) begin
      fa = funct_alu(funct);
      o = base(); o.src_a = 1; o.alu = fa[2:0];
      if (!fa[3]) begin
        o.illegal = 1;
        push(0, op, funct, ro, zero, o);
        return;
      end
      push(0, op, funct, ro, zero, o);
      o = base(); o.reg_dst = 1; o.reg_write = 1;
      push(0, op, funct, ro, zero, o);
    end else if (op == T_BEQ || op == T_BNE) begin
      o = base(); o.src_a = 1; o.alu = 3'b110; o.pc_src = 2'b01;
      o.pc_en = (op == T_BNE) ? !zero : zero;
      push(0, op, funct, ro, zero, o);
    end else if (op == T_ADDI) begin
      o = base(); o.src_a = 1; o.src_b = 2'b10;
      push(0, op, funct, ro, zero, o);
      o = base(); o.reg_write = 1;
      push(0, op, funct, ro, zero, o);
    end else begin
      o = base(); o.pc_src = 2'b10; o.pc_en = 1;
      push(0, op, funct, ro, zero, o);
    end
  endtask

  initial begin
    rec_t r;
    int cyc;
    // program: ids 1..20
    reset_cycle(); reset_cycle(); reset_cycle();
    instr(T_R,    6'b100000, 0, 0, 0, 1);   // 1  add
    instr(T_LW,   6'b000000, 0, 0, 2, 1);   // 2  lw, 2 memory waits
    instr(T_LW,   6'b000000, 1, 0, 0, 1);   // 3
    instr(T_SW,   6'b000000, 0, 0, 0, 1);   // 4
    instr(T_SW,   6'b000000, 0, 1, 1, 1);   // 5  fetch and store waits
    instr(T_BEQ,  6'b000000, 1, 0, 0, 1);   // 6  taken
    instr(T_BEQ,  6'b000000, 0, 0, 0, 1);   // 7  not taken
    instr(T_ADDI, 6'b000000, 0, 0, 0, 1);   // 8
    instr(T_J,    6'b000000, 0, 0, 0, 1);   // 9
    instr(T_R,    6'b100010, 1, 0, 0, 0);   // 10 sub, MemReady low outside accesses
    instr(T_R,    6'b100100, 0, 0, 0, 1);   // 11 and
    instr(T_R,    6'b100101, 0, 0, 0, 1);   // 12 or
    instr(T_R,    6'b101010, 0, 0, 0, 1);   // 13 slt
    instr(T_BAD,  6'b000000, 0, 0, 0, 1);   // 14 illegal opcode
    instr(T_R,    6'b111111, 0, 0, 0, 1);   // 15 illegal funct
    instr(T_BNE,  6'b000000, 0, 0, 0, 1);   // 16
    instr(T_BNE,  6'b000000, 1, 0, 0, 1);   // 17
    instr(T_R,    6'b100000, 0, 0, 0, 1);   // 18 aborted by reset in its writeback cycle
    void'(q.pop_back());
    reset_cycle();
    instr(T_J,    6'b000000, 0, 0, 0, 1);   // 19
    instr(T_J,    6'b000000, 0, 0, 0, 1);   // 20

    exp_int = '{4, 7, 5, 5, 5, 3, 3, 4, 3, 4, 4, 4, 4, 2, 3, BNE_LEN, BNE_LEN, 4, 3};

    cyc = 0;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge CLK);
      Reset = r.rst; Op = r.op; Funct = r.funct; MemReady = r.rdy; Zero = r.zero;
      #1;
      checks++;
      if (act !== r.exp) begin
        errors++;
        $display("FAIL outputs cyc=%0d instr=%0d got=%b want=%b", cyc, r.id, act, r.exp);
      end
      if (act.ir_write === 1'b1) irw.push_back(cyc);
      cyc++;
    end

    // literal instruction lengths, measured between DUT IRWrite pulses
    checks++;
    if (irw.size() != 20) begin
      errors++;
      $display("FAIL irwrite_count got=%0d want=20", irw.size());
    end else begin
      checks++;
      if (irw[0] != 3) begin
        errors++;
        $display("FAIL first_fetch_cycle got=%0d want=3", irw[0]);
      end
      for (int i = 0; i < 19; i++) begin
        checks++;
        if (irw[i+1] - irw[i] != exp_int[i]) begin
          errors++;
          $display("FAIL instr_len instr=%0d got=%0d want=%0d", i + 1, irw[i+1] - irw[i], exp_int[i]);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Moore-style control FSM that sequences a multicycle MIPS datapath built from the team's existing register file, ALU, sign-extend, shifter, adder, mux and PC units. It shares one unified instruction/data memory port across fetch and data phases. It adds a memory-ready handshake so slow memories can stall the machine. It decodes opcode/funct, steps each instruction through fetch, decode, execute, memory and writeback, and drives every datapath select and write enable.

## Interface
- No parameters; opcode, funct and ALUControl encodings are fixed constants in the package.
- CLK  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- Op  in  6  Instr[31:26] from the instruction register.
- Funct  in  6  Instr[5:0].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- MemReq  out  1  memory access in progress.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  store strobe, valid with MemReq.
- IRWrite  out  1  load instruction register.
- RegDST, MemtoReg, RegWrite  out  1 each  register-file controls.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- PCEn  out  1  PC register enable.
- Illegal  out  1  one-cycle pulse on an undecodable opcode or funct.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
- FETCH:
  - Drives MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00.
  - Holds until MemReady=1. In that cycle it asserts IRWrite=1 and PCEn=1, then moves to DECODE.
- DECODE: drives ALUSrcA=0, ALUSrcB=11, add (branch target precompute), then branches on Op.
  - lw/sw (100011/101011) -> MEMADR.
  - R-type (000000) -> EXECUTE.
  - beq (000100) -> BRANCH.
  - addi (001000) -> ADDIEXEC.
  - j (000010) -> JUMP.
  - Any other Op: Illegal=1, -> FETCH.
- MEMADR: drives ALUSrcA=1, ALUSrcB=10, add. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: MemReq=1, IorD=1. Holds until MemReady, then -> MEMWB.
- MEMWB: RegDST=0, MemtoReg=1, RegWrite=1, -> FETCH.
- MEMWRITE: MemReq=1, IorD=1, MemWrite=1. Holds until MemReady, then -> FETCH.
- EXECUTE: drives ALUSrcA=1, ALUSrcB=00, with ALUControl from Funct.
  - Funct mapping: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown Funct: Illegal=1, -> FETCH, and ALUWB is skipped.
- ALUWB: RegDST=1, MemtoReg=0, RegWrite=1, -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01. PCEn=Zero. -> FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, add. ADDIWB: RegDST=0, MemtoReg=0, RegWrite=1. Then -> FETCH.
- JUMP: PCSrc=10, PCEn=1, -> FETCH.
- Any output not listed for a state is 0; ALUControl default is 010.

## Timing
- State register updates on the rising CLK edge. Outputs decode from state, except:
  - IRWrite, PCEn in FETCH are gated by MemReady.
  - PCEn in BRANCH is gated by Zero.
- Reset=1 at an edge: state <= FETCH. While Reset is high, MemReq, MemWrite, IRWrite, PCEn, RegWrite and Illegal are forced to 0. All other outputs show FETCH values: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00.
- Reset mid-instruction aborts it: no writeback and no PC update occur in the reset cycle.
- Cycle counts with zero-wait memory (MemReady held 1):
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each wait cycle adds one cycle in FETCH, MEMREAD or MEMWRITE.
- MemReq stays high, with address and MemWrite stable, until MemReady=1. MemReady outside MemReq is ignored.
- Illegal pulses for exactly one cycle in DECODE or EXECUTE; the next state is FETCH.

## Configuration
- CTRL_BNE_EN defined:
  - Op 000101 decodes to BRANCH with sub and PCSrc=01.
  - PCEn = Zero for beq and PCEn = ~Zero for bne; Op is held in the IR, so it is stable.
- Not defined: 000101 is illegal (Illegal pulse, -> FETCH).

## Structure
- Package mips_ctrl_pkg holds:
  - state enum;
  - OP_* and FUNCT_* constants;
  - ALU_ADD/SUB/AND/OR/SLT encodings;
  - SRCB_* and PCSRC_* select constants.
- One sub-module, mips_alu_decoder: combinational map of {ALUOp[1:0], Funct} to {ALUControl, funct_illegal}. It is instantiated once.

## Test plan
- Reset held 3 cycles, then released with MemReady=1:
  - During reset, all enables are 0.
  - In the first cycle after release, FETCH asserts MemReq=1, IRWrite=1, PCEn=1.
- R-type add (Op 000000, Funct 100000):
  - States FETCH, DECODE, EXECUTE, ALUWB.
  - ALUControl=010 in EXECUTE; RegWrite=1 and RegDST=1 in cycle 4.
- lw with MemReady low for 2 cycles in MEMREAD:
  - MemReq=1 and IorD=1 held 3 cycles.
  - MEMWB follows with MemtoReg=1 and RegWrite=1; 7 cycles total.
- beq with Zero=1, then a second beq with Zero=0:
  - PCEn=1 in BRANCH with PCSrc=01 for the first; PCEn=0 for the second.
  - Each takes 3 cycles.
- Op 111111:
  - Illegal=1 for exactly one cycle in DECODE; FETCH next cycle; no RegWrite or MemWrite.
- Op 000101 with Zero=0:
  - With CTRL_BNE_EN: PCEn=1 in BRANCH.
  - Without it: Illegal=1.
